// File: rtl/basic_gates_pkg.sv
// basic_gates_pkg: shared constants and per-bit result record; xor_b exists only with BASIC_GATES_XOR_EN
package basic_gates_pkg;
  localparam int DEFAULT_WIDTH = 1;
  localparam int MAX_WIDTH = 64;
  typedef struct packed {
    logic and_b;
    logic or_b;
    logic not_b;
`ifdef BASIC_GATES_XOR_EN
    logic xor_b;
`endif
  } gate_result_t;
endpackage

// File: rtl/basic_gate_cell.sv
// basic_gate_cell: combinational single-bit gate slice; xor_o exists only with BASIC_GATES_XOR_EN
module basic_gate_cell (
  input  logic a,
  input  logic b,
  output logic and_o,
  output logic or_o,
`ifdef BASIC_GATES_XOR_EN
  output logic xor_o,
`endif
  output logic not_o
);
  assign and_o = a & b;
  assign or_o  = a | b;
  assign not_o = ~a;
`ifdef BASIC_GATES_XOR_EN
  assign xor_o = a ^ b;
`endif
endmodule

// File: rtl/basic_gates.sv
// basic_gates: registered, valid-qualified bitwise AND/OR/NOT unit; XOR output enabled by BASIC_GATES_XOR_EN
module basic_gates
  import basic_gates_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  output logic [WIDTH-1:0] and_y,
  output logic [WIDTH-1:0] or_y,
`ifdef BASIC_GATES_XOR_EN
  output logic [WIDTH-1:0] xor_y,
`endif
  output logic [WIDTH-1:0] not_y
);
  gate_result_t w_res [WIDTH];
  gate_result_t r_res [WIDTH];
  logic         r_valid;
  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    basic_gate_cell u_cell (
      .a     (a[i]),
      .b     (b[i]),
      .and_o (w_res[i].and_b),
      .or_o  (w_res[i].or_b),
`ifdef BASIC_GATES_XOR_EN
      .xor_o (w_res[i].xor_b),
`endif
      .not_o (w_res[i].not_b)
    );
    assign and_y[i] = r_res[i].and_b;
    assign or_y[i]  = r_res[i].or_b;
    assign not_y[i] = r_res[i].not_b;
`ifdef BASIC_GATES_XOR_EN
    assign xor_y[i] = r_res[i].xor_b;
`endif
  end
  // Results load only on valid, so operands are don't-care otherwise
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_valid <= 1'b0;
      r_res   <= '{default: '0};
    end else begin
      r_valid <= in_valid;
      if (in_valid) r_res <= w_res;
    end
  end
  assign out_valid = r_valid;
endmodule

// File: tb/tb_basic_gates.sv
// tb_basic_gates: table-driven check of basic_gates at WIDTH=8 and WIDTH=1; XOR checks follow BASIC_GATES_XOR_EN
module tb_basic_gates;
  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       in_valid = 1'b0;
  logic [7:0] a8 = '0, b8 = '0;
  logic       a1 = 1'b0, b1 = 1'b0;
  logic       ov8, ov1;
  logic [7:0] and8, or8, not8;
  logic       and1, or1, not1;
`ifdef BASIC_GATES_XOR_EN
  logic [7:0] xor8;
  logic       xor1;
`endif
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  basic_gates #(.WIDTH(8)) d8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a8), .b(b8),
    .out_valid(ov8), .and_y(and8), .or_y(or8),
`ifdef BASIC_GATES_XOR_EN
    .xor_y(xor8),
`endif
    .not_y(not8)
  );

  basic_gates #(.WIDTH(1)) d1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .a(a1), .b(b1),
    .out_valid(ov1), .and_y(and1), .or_y(or1),
`ifdef BASIC_GATES_XOR_EN
    .xor_y(xor1),
`endif
    .not_y(not1)
  );

  typedef struct {
    logic [7:0] a, b, and_e, or_e, not_e, xor_e;
  } vec_t;

  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", n, act, exp);
    end
  endtask

  task automatic check_all(input string t, input logic [7:0] ae, input logic [7:0] oe,
                           input logic [7:0] ne, input logic [7:0] xe, input logic ve);
    chk({t, " w8 out_valid"}, 64'(ov8), 64'(ve));
    chk({t, " w8 and"}, 64'(and8), 64'(ae));
    chk({t, " w8 or"}, 64'(or8), 64'(oe));
    chk({t, " w8 not"}, 64'(not8), 64'(ne));
    chk({t, " w1 out_valid"}, 64'(ov1), 64'(ve));
    chk({t, " w1 and"}, 64'(and1), 64'(ae[0]));
    chk({t, " w1 or"}, 64'(or1), 64'(oe[0]));
    chk({t, " w1 not"}, 64'(not1), 64'(ne[0]));
`ifdef BASIC_GATES_XOR_EN
    chk({t, " w8 xor"}, 64'(xor8), 64'(xe));
    chk({t, " w1 xor"}, 64'(xor1), 64'(xe[0]));
`else
    if (xe === 8'hxx) $display("unexpected x in xor expectation");
`endif
  endtask

  task automatic drive(input logic r, input logic v, input logic [7:0] a, input logic [7:0] b);
    @(negedge clk);
    rst_n = r;
    in_valid = v;
    a8 = a;
    b8 = b;
    a1 = a[0];
    b1 = b[0];
    @(posedge clk);
    #1;
  endtask

  vec_t tbl [8];

  initial begin
    tbl[0] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'hFF, 8'h00};
    tbl[1] = '{8'h00, 8'h01, 8'h00, 8'h01, 8'hFF, 8'h01};
    tbl[2] = '{8'h01, 8'h00, 8'h00, 8'h01, 8'hFE, 8'h01};
    tbl[3] = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h00, 8'h00};
    tbl[4] = '{8'hF0, 8'h3C, 8'h30, 8'hFC, 8'h0F, 8'hCC};
    tbl[5] = '{8'hA5, 8'h5A, 8'h00, 8'hFF, 8'h5A, 8'hFF};
    tbl[6] = '{8'hC3, 8'h96, 8'h82, 8'hD7, 8'h3C, 8'h55};
    tbl[7] = '{8'h81, 8'hFF, 8'h81, 8'hFF, 8'h7E, 8'h7E};

    // Reset held with live operands: everything stays zero, including not_y
    for (int i = 0; i < 3; i++) drive(1'b0, 1'b1, 8'hFF, 8'hFF);
    check_all("reset", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    drive(1'b0, 1'b1, 8'h00, 8'h00);
    check_all("reset zero-a", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);

    // Back-to-back truth table and vectors
    foreach (tbl[i]) begin
      drive(1'b1, 1'b1, tbl[i].a, tbl[i].b);
      check_all($sformatf("vec%0d", i), tbl[i].and_e, tbl[i].or_e, tbl[i].not_e, tbl[i].xor_e, 1'b1);
    end

    // Hold: last vector (81/FF) stays while in_valid is low
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 8'h00, 8'h00);
      check_all($sformatf("hold%0d", i), 8'h81, 8'hFF, 8'h7E, 8'h7E, 1'b0);
    end

    // Capture 11 then hold with zero operands
    drive(1'b1, 1'b1, 8'hFF, 8'hFF);
    check_all("cap11", 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b1);
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, 8'h00, 8'h00);
      check_all($sformatf("hold11_%0d", i), 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0);
    end

    // A reset pulse between edges is ignored
    @(negedge clk);
    rst_n = 1'b0;
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_all("glitch", 8'hFF, 8'hFF, 8'h00, 8'h00, 1'b0);

    // Reset for one edge inside a valid stream
    drive(1'b1, 1'b1, 8'h0F, 8'h33);
    check_all("mid pre", 8'h03, 8'h3F, 8'hF0, 8'h3C, 1'b1);
    drive(1'b0, 1'b1, 8'hFF, 8'hFF);
    check_all("mid rst", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    drive(1'b1, 1'b1, 8'h55, 8'h0F);
    check_all("mid post", 8'h05, 8'h5F, 8'hAA, 8'h5A, 1'b1);
    drive(1'b1, 1'b0, 8'h00, 8'h00);
    check_all("mid idle", 8'h05, 8'h5F, 8'hAA, 8'h5A, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/basic_gates.md
# basic_gates

Registered bitwise logic unit computing AND, OR and NOT of its operands (XOR optional) over a configurable width. It is the elementary building block for combinational logic stages in datapath designs. It gives downstream logic a single-cycle, valid-qualified, resettable result bus. Each bit slice is an independent gate cell.

## Interface
- WIDTH, default 1: operand and result width in bits; legal range 1..64.
- clk  input  1  rising-edge clock.
- rst_n  input  1  synchronous reset, active-low; sampled only on the rising edge of clk.
- in_valid  input  1  operands a/b are valid this cycle.
- a  input  WIDTH  first operand; also the NOT source.
- b  input  WIDTH  second operand.
- out_valid  output  1  result registers updated on the previous edge.
- and_y  output  WIDTH  registered a & b.
- or_y  output  WIDTH  registered a | b.
- not_y  output  WIDTH  registered ~a; b is ignored for this output.
- xor_y  output  WIDTH  registered a ^ b; present only with BASIC_GATES_XOR_EN.

## Operation
- At a rising edge with rst_n=1 and in_valid=1:
  - and_y <= a & b, or_y <= a | b, not_y <= ~a (and xor_y <= a ^ b if enabled).
  - All operations are bitwise; bit i of each result depends only on a[i] and b[i].
- At a rising edge with rst_n=1 and in_valid=0: all result registers hold their value.
- out_valid <= in_valid on every non-reset edge, so it is a one-cycle-delayed copy of in_valid.
- No carries, no width extension and no truncation; every result is exactly WIDTH bits.
- X/Z on a or b while in_valid=0 must not disturb the results.

## Timing
- Latency is 1 cycle: operands sampled at edge N are visible on the outputs after edge N; out_valid is high during the cycle following edge N.
- Throughput is one operation per cycle; back-to-back in_valid is fully supported.
- No backpressure; the consumer must take the result while out_valid is high.
- Reset state: out_valid=0, and_y=0, or_y=0, xor_y=0, and not_y=0.
  - not_y is forced to 0 during reset; it does not track ~a.
- Reset has priority over in_valid at the same edge. Operands presented with rst_n=0 are discarded.
- Reset asserted mid-stream clears all outputs at that edge. The first edge after release with in_valid=1 produces fresh results.
- Asynchronous changes of rst_n between edges have no effect.

## Configuration
- BASIC_GATES_XOR_EN defined:
  - The xor_y port and its register exist.
  - xor_y resets to 0, updates and holds under the same in_valid rules as the other results.
- BASIC_GATES_XOR_EN undefined:
  - The xor_y port is absent.
  - No XOR logic is synthesised.

## Structure
- Package basic_gates_pkg holds:
  - constant DEFAULT_WIDTH = 1 and MAX_WIDTH = 64;
  - struct gate_result_t with fields and_b, or_b, not_b and, under the macro, xor_b.
- Sub-module basic_gate_cell: a purely combinational single-bit cell (inputs a, b; outputs for each gate).
  - The top instantiates WIDTH cells in a generate loop.
  - The top owns all registers, the reset logic and valid tracking.

## Test plan
- Reset: hold rst_n=0 for 3 cycles with a=1, b=1, in_valid=1 -> all results 0 and out_valid=0 throughout.
- Truth table, WIDTH=1: present (a,b) = 00, 01, 10, 11 on consecutive cycles with in_valid=1 -> one cycle later and/or/not respectively:
  - 00 -> 0/0/1
  - 01 -> 0/1/1
  - 10 -> 0/1/0
  - 11 -> 1/1/0
  - With the macro, xor = 0, 1, 1, 0.
- Hold: after a=1, b=1 is captured, drive a=0, b=0 with in_valid=0 for 4 cycles -> and_y stays 1, not_y stays 0, out_valid=0.
- Vector, WIDTH=8: a=8'hF0, b=8'h3C -> and_y=8'h30, or_y=8'hFC, not_y=8'h0F, xor_y=8'hCC.
- Reset mid-stream: pull rst_n low for one edge during back-to-back valid inputs -> outputs 0 at that edge; the next valid pair appears one cycle after release.
- Macro off: compile without BASIC_GATES_XOR_EN -> no xor_y port exists, and the other results match the truth-table case.
